// File: rtl/lcd_hd44780_ctrl_if.sv
// CPU custom-instruction side of the HD44780 controller: clock enable, start/done handshake and operands.
// Master is the CPU, slave is the controller.
interface lcd_hd44780_ctrl_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    modport master (output clk_en, start, dataa, datab, input result, done);
    modport slave  (input clk_en, start, dataa, datab, output result, done);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write-only controller: one byte per start, timed setup/pulse/hold on en, 8- or 4-bit bus, post-write wait.
// Latency: done at T+1+(SETUP+EN+HOLD)*passes+WAIT; start is ignored outside IDLE, clk_en low freezes everything.
// Optional backlight register selected by macro LCD_BACKLIGHT_CTRL_EN (default: bl tied high).
module lcd_hd44780_ctrl #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BUS_WIDTH      = 8,
    parameter int SETUP_CYCLES   = 2,
    parameter int EN_CYCLES      = 25,
    parameter int HOLD_CYCLES    = 2,
    parameter int DELAY_SHORT_US = 40,
    parameter int DELAY_LONG_US  = 1640
) (
    input  logic                     clk,
    input  logic                     reset,
    lcd_hd44780_ctrl_if.slave        ci,
    output logic                     bl,
    output logic                     rs,
    output logic                     rw,
    output logic                     en,
    output logic [7:0]               db
);
    localparam int WAIT_S = int'((longint'(CLK_HZ) * longint'(DELAY_SHORT_US) + 64'sd999_999) / 64'sd1_000_000);
    localparam int WAIT_L = int'((longint'(CLK_HZ) * longint'(DELAY_LONG_US) + 64'sd999_999) / 64'sd1_000_000);
    localparam int MAX_A  = (WAIT_L > WAIT_S) ? WAIT_L : WAIT_S;
    localparam int MAX_B  = (MAX_A > EN_CYCLES) ? MAX_A : EN_CYCLES;
    localparam int MAX_C  = (MAX_B > SETUP_CYCLES) ? MAX_B : SETUP_CYCLES;
    localparam int MAX_D  = (MAX_C > HOLD_CYCLES) ? MAX_C : HOLD_CYCLES;
    localparam int CW     = $clog2(MAX_D + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    db_q, db_d;
    logic [3:0]    lo_nib_q, lo_nib_d;
    logic          single_q, single_d;
    logic          second_q, second_d;
    logic          long_q, long_d;
    logic [31:0]   result_q, result_d;
`ifdef LCD_BACKLIGHT_CTRL_EN
    logic          bl_q, bl_d;
`endif

    logic unused_bits;
`ifdef LCD_BACKLIGHT_CTRL_EN
    assign unused_bits = ^{ci.dataa[31:3], ci.datab[31:8]};
`else
    assign unused_bits = ^{ci.dataa[31:3], ci.dataa[1], ci.datab[31:8]};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        db_d     = db_q;
        lo_nib_d = lo_nib_q;
        single_d = single_q;
        second_d = second_q;
        long_d   = long_q;
        result_d = result_q;
`ifdef LCD_BACKLIGHT_CTRL_EN
        bl_d     = bl_q;
`endif
        if (ci.clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (ci.start) begin
                        rs_d     = ci.dataa[0];
                        db_d     = (BUS_WIDTH == 8) ? ci.datab[7:0] : {ci.datab[7:4], 4'h0};
                        lo_nib_d = ci.datab[3:0];
                        single_d = ci.dataa[2];
                        second_d = 1'b0;
                        // Clear and return-home need the long execution time.
                        long_d   = !ci.dataa[0] && (ci.datab[7:2] == 6'd0) && (ci.datab[1:0] != 2'd0);
                        cnt_d    = CW'(SETUP_CYCLES - 1);
                        state_d  = S_SETUP;
`ifdef LCD_BACKLIGHT_CTRL_EN
                        bl_d     = ci.dataa[1];
`endif
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        cnt_d   = CW'(EN_CYCLES - 1);
                        state_d = S_PULSE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        if (BUS_WIDTH == 4 && !second_q && !single_q) begin
                            second_d = 1'b1;
                            db_d     = {lo_nib_q, 4'h0};
                            cnt_d    = CW'(SETUP_CYCLES - 1);
                            state_d  = S_SETUP;
                        end else begin
                            cnt_d   = long_q ? CW'(WAIT_L - 1) : CW'(WAIT_S - 1);
                            state_d = S_WAIT;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        result_d = 32'h1;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rs_q     <= 1'b0;
            db_q     <= 8'h00;
            lo_nib_q <= 4'h0;
            single_q <= 1'b0;
            second_q <= 1'b0;
            long_q   <= 1'b0;
            result_q <= 32'h0;
`ifdef LCD_BACKLIGHT_CTRL_EN
            bl_q     <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            db_q     <= db_d;
            lo_nib_q <= lo_nib_d;
            single_q <= single_d;
            second_q <= second_d;
            long_q   <= long_d;
            result_q <= result_d;
`ifdef LCD_BACKLIGHT_CTRL_EN
            bl_q     <= bl_d;
`endif
        end
    end

    // en decodes straight from state so an async reset drops it at once.
    assign en        = (state_q == S_PULSE);
    assign rs        = rs_q;
    assign db        = db_q;
    assign rw        = 1'b0;
    assign ci.done   = (state_q == S_DONE);
    assign ci.result = result_q;
`ifdef LCD_BACKLIGHT_CTRL_EN
    assign bl        = bl_q;
`else
    assign bl        = 1'b1;
`endif
endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Parametrised successor to the team's Nios II custom-instruction LCD writer for HD44780-class character displays.
- Adds:
  - timing derived from CLK_HZ
  - explicit setup/pulse/hold phases on en
  - 8-bit or 4-bit bus mode
  - automatic long delay for clear/home commands
  - single-nibble init writes
- Sits on the CPU custom-instruction port (start/done handshake) and drives the LCD pins directly.

Parameters:
- CLK_HZ, 50_000_000, clk frequency in Hz.
- BUS_WIDTH, 8, LCD data bus width; legal values 8 or 4.
- SETUP_CYCLES, 2, rs/db valid before en rises (tAS); minimum 1.
- EN_CYCLES, 25, en high time per transfer (PWEH); minimum 1.
- HOLD_CYCLES, 2, rs/db held after en falls (tAH); minimum 1.
- DELAY_SHORT_US, 40, execution wait for normal commands and data.
- DELAY_LONG_US, 1640, execution wait for clear (0x01) and return-home (0x02/0x03).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  custom-instruction clock enable; when low, all state and counters freeze
- start  in  1  request; sampled only in IDLE with clk_en high
- dataa  in  32  [0]=rs, [1]=backlight request (see optional feature), [2]=single-nibble flag; [31:3] ignored
- datab  in  32  [7:0]=byte to write; [31:8] ignored
- result  out  32  completion code, valid while done is high
- done  out  1  one-cycle completion pulse
- bl  out  1  backlight
- rs  out  1  LCD register select
- rw  out  1  tied 0 (write only)
- en  out  1  LCD enable strobe
- db  out  8  LCD data; in 4-bit mode the nibble is on db[7:4] and db[3:0]=0

Behaviour:
- Reset values: rs=0, en=0, db=0, done=0, result=0, bl=1, state=IDLE, counters=0. Reset mid-operation drops en immediately and abandons the transfer; no done is issued.
- All timing below counts clk_en-high cycles only.
- WAIT_S = ceil(CLK_HZ*DELAY_SHORT_US/1e6); WAIT_L likewise. Counter width = $clog2(max(WAIT_L, EN_CYCLES, ...)+1).
- States: IDLE -> SETUP -> PULSE -> HOLD -> (NIBBLE2: back to SETUP) -> WAIT -> DONE -> IDLE.
- IDLE: done=0. On start in cycle T:
  - latch rs=dataa[0], byte=datab[7:0] and the single-nibble flag
  - set long_wait = (rs==0 and byte in {0x01,0x02,0x03})
  - drive db with the first transfer from T+1
- SETUP: en=0 for SETUP_CYCLES. PULSE: en=1 for EN_CYCLES. HOLD: en=0 for HOLD_CYCLES; db and rs stable throughout.
- 8-bit mode: one SETUP/PULSE/HOLD pass.
- 4-bit mode: first pass sends byte[7:4], second pass sends byte[3:0], back to back with no wait between. If the single-nibble flag is set, only byte[7:4] is sent (HD44780 init sequence). The flag is ignored in 8-bit mode.
- WAIT: WAIT_L cycles if long_wait, else WAIT_S. en=0; db and rs hold their last value.
- DONE: done=1 and result=32'h1 for exactly one cycle, then IDLE.
  - Done cycle in 8-bit mode = T+1+SETUP+EN+HOLD+WAIT.
  - Each extra nibble adds SETUP+EN+HOLD.
- start outside IDLE is ignored (not queued).
- start held high continuously re-triggers only after the return to IDLE; the earliest next acceptance is the cycle after done.
- result holds its last value after done falls.
- clk_en low in any state freezes outputs exactly, including an en pulse in progress, which is stretched rather than cut.

Optional Feature:
- LCD_BACKLIGHT_CTRL_EN defined:
  - bl is a register, reset 1, loaded from dataa[1] on every accepted start.
  - Loading takes effect at T+1.
- LCD_BACKLIGHT_CTRL_EN undefined:
  - bl is tied to 1 and dataa[1] is ignored.

Test Plan:
- Sim parameters for all cases: CLK_HZ=1_000_000, SETUP=2, EN=4, HOLD=2, SHORT=40, LONG=1640.
- 8-bit data write, dataa=1, datab=0x41 at T -> rs=1, db=0x41 from T+1; en high T+3..T+6; done only at T+49; result=1.
- 8-bit command 0x01 -> rs=0; done at T+1649. Command 0x38 -> done at T+49.
- BUS_WIDTH=4, datab=0x28 -> db=0x20 with en high T+3..T+6, then db=0x80 with en high T+11..T+14; done at T+57. Repeat with dataa[2]=1 -> only the 0x20 nibble is sent; done at T+49.
- Second start asserted mid-WAIT -> ignored, no second en pulse; start held across done -> next transfer accepted the cycle after done.
- clk_en low for 10 cycles during PULSE -> en high for 14 cycles total; done delayed by exactly 10 cycles.
- reset pulsed during PULSE -> en=0 and db=0 asynchronously, no done; a new start afterwards completes normally. With LCD_BACKLIGHT_CTRL_EN, a write with dataa[1]=0 -> bl=0 from T+1.
